rgb_fade_pwm: RTL

RGB_FADE_PWM -- requirements
Module: rgb_fade_pwm

---
 rtl/rgb_fade_pkg.sv | 37 +++
 rtl/rgb_fade_pwm_if.sv | 23 ++
 rtl/pwm_shadow_chan.sv | 46 ++++
 rtl/rgb_fade_pwm.sv | 120 ++++++++++++
 4 files changed

// File: rtl/rgb_fade_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_fade_pkg
//  Description : Shared types and constants for the RGB fade / PWM block.
//                FSM state type, PWM width, default step divider, colour
//                triple type and a one-step ramp helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package rgb_fade_pkg;

  localparam int PWM_W            = 8;
  localparam int STEP_DIV_DEFAULT = 48000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FADE = 2'd2
  } fade_state_e;

  typedef logic [PWM_W-1:0] duty_t;

  typedef struct packed {
    duty_t r;
    duty_t g;
    duty_t b;
  } rgb_t;

  // Move one count toward the target; never overshoots and never wraps
  // because the comparison guards both directions.
  function automatic duty_t step_toward(input duty_t cur, input duty_t tgt);
    if (cur < tgt)      return cur + duty_t'(1);
    else if (cur > tgt) return cur - duty_t'(1);
    else                return cur;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rgb_fade_pwm_if.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_fade_pwm_if
//  Description : Colour-target valid/ready handshake.
//                master : drives tgt_valid and tgt_r/g/b, receives tgt_ready
//                slave  : receives the offer, drives tgt_ready
//  Revision    : 1.0 - initial release
// ============================================================================
interface rgb_fade_pwm_if;
  import rgb_fade_pkg::*;

  logic  tgt_valid;
  logic  tgt_ready;
  duty_t tgt_r;
  duty_t tgt_g;
  duty_t tgt_b;

  modport master (output tgt_valid, output tgt_r, output tgt_g, output tgt_b,
                  input  tgt_ready);
  modport slave  (input  tgt_valid, input  tgt_r, input  tgt_g, input  tgt_b,
                  output tgt_ready);
endinterface
`default_nettype wire

// File: rtl/pwm_shadow_chan.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_shadow_chan
//  Description : One PWM output channel. Duty is captured into a shadow
//                register only at the end of a PWM period so a duty change
//                never shortens or lengthens the period in progress.
//  Ports       : clk, rst_n   - clock, async active-low reset
//                pwm_cnt      - shared free-running 8-bit period counter
//                duty         - requested duty (0..255)
//                led_n        - registered active-low drive
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_shadow_chan
  import rgb_fade_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  duty_t pwm_cnt,
  input  duty_t duty,
  output logic  led_n
);

  duty_t shadow_q, shadow_d;
  logic  led_n_q,  led_n_d;

  always_comb begin
    shadow_d = shadow_q;
    if (pwm_cnt == '1) shadow_d = duty;
    // Strict compare: duty 0 is never on, duty 255 is off only at count 255.
    led_n_d = !(pwm_cnt < shadow_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      led_n_q  <= 1'b1;
    end else begin
      shadow_q <= shadow_d;
      led_n_q  <= led_n_d;
    end
  end

  assign led_n = led_n_q;

endmodule
`default_nettype wire

// File: rtl/rgb_fade_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_fade_pwm
//  Description : Accepts RGB colour targets over a valid/ready handshake into
//                a one-entry pending slot, ramps the current colour toward
//                the active target one count per step tick, and drives three
//                active-low PWM outputs from the ramped colour.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                tgt (slave)         - tgt_valid/tgt_ready, tgt_r/g/b
//                busy                - FSM not in IDLE
//                cur_r/g/b           - current ramped duty
//                led_r_n/g_n/b_n     - registered active-low PWM drive
//  Revision    : 1.0 - initial release
// ============================================================================
module rgb_fade_pwm
  import rgb_fade_pkg::*;
#(
  parameter int STEP_DIV = STEP_DIV_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  rgb_fade_pwm_if.slave tgt,
  output logic          busy,
  output duty_t         cur_r,
  output duty_t         cur_g,
  output duty_t         cur_b,
  output logic          led_r_n,
  output logic          led_g_n,
  output logic          led_b_n
);

  localparam int               PRE_W    = $clog2(STEP_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);

  fade_state_e      state_q, state_d;
  logic             pend_full_q, pend_full_d;
  rgb_t             pend_q, pend_d;
  rgb_t             act_q, act_d;
  rgb_t             cur_q, cur_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  duty_t            pwm_cnt_q, pwm_cnt_d;

  logic w_xfer, w_tick, w_at_tgt, w_pop, w_fade;

  assign w_xfer   = tgt.tgt_valid && !pend_full_q;
  assign w_tick   = (pre_q == PRE_LAST);
  assign w_at_tgt = (cur_q == act_q);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (pend_full_q) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_FADE;
      ST_FADE: if (w_at_tgt) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy   = (state_q != ST_IDLE);
    w_pop  = (state_q == ST_LOAD);
    w_fade = (state_q == ST_FADE);
  end

  // ---------------- datapath next values ----------------
  always_comb begin
    // Pop-then-fill: a fill in the same cycle as a pop keeps the slot full.
    pend_full_d = (pend_full_q && !w_pop) || w_xfer;
    pend_d      = w_xfer ? rgb_t'{r: tgt.tgt_r, g: tgt.tgt_g, b: tgt.tgt_b} : pend_q;
    act_d       = w_pop ? pend_q : act_q;

    cur_d = cur_q;
    if (w_fade && w_tick) begin
      cur_d.r = step_toward(cur_q.r, act_q.r);
      cur_d.g = step_toward(cur_q.g, act_q.g);
      cur_d.b = step_toward(cur_q.b, act_q.b);
    end

    // Free-running; handshakes never touch the step phase.
    pre_d     = w_tick ? '0 : pre_q + PRE_W'(1);
    pwm_cnt_d = pwm_cnt_q + duty_t'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full_q <= 1'b0;
      pend_q      <= '0;
      act_q       <= '0;
      cur_q       <= '0;
      pre_q       <= '0;
      pwm_cnt_q   <= '0;
    end else begin
      pend_full_q <= pend_full_d;
      pend_q      <= pend_d;
      act_q       <= act_d;
      cur_q       <= cur_d;
      pre_q       <= pre_d;
      pwm_cnt_q   <= pwm_cnt_d;
    end
  end

  assign tgt.tgt_ready = !pend_full_q;
  assign cur_r = cur_q.r;
  assign cur_g = cur_q.g;
  assign cur_b = cur_q.b;

  pwm_shadow_chan u_chan_r (.clk(clk), .rst_n(rst_n), .pwm_cnt(pwm_cnt_q), .duty(cur_q.r), .led_n(led_r_n));
  pwm_shadow_chan u_chan_g (.clk(clk), .rst_n(rst_n), .pwm_cnt(pwm_cnt_q), .duty(cur_q.g), .led_n(led_g_n));
  pwm_shadow_chan u_chan_b (.clk(clk), .rst_n(rst_n), .pwm_cnt(pwm_cnt_q), .duty(cur_q.b), .led_n(led_b_n));

endmodule
`default_nettype wire
